flag_branch_unit: RTL and testbench
===================================

Name: flag_branch_unit

Overview:
- Consumes the 1-bit zero-detect output (z) of the 8-bit datapath, together with the ALU carry, sign and overflow bits.
- Holds them in a registered Z/C/N/V status register.
- Evaluates 3-bit branch conditions against that register and returns a registered taken/not-taken result one cycle after each request.
- Keeps a saturating count of consecutive zero results, used by loop-control logic.

Parameters:
- BYPASS, 1, when 1 a branch request in the same cycle as a flag update is evaluated against the incoming flags; when 0 it is evaluated against the stored flags.
- ZRUN_W, 4, width of the consecutive-zero run counter.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous reset, active-high
- flag_we  input  1  capture z_in/c_in/n_in/v_in this cycle
- z_in  input  1  zero flag from the zero detector (1 when the 8-bit result is 0x00)
- c_in  input  1  ALU carry out
- n_in  input  1  ALU result bit 7
- v_in  input  1  ALU signed overflow
- flags_clr  input  1  clear Z/C/N/V and the run counter
- br_req  input  1  branch evaluation request
- cond  input  3  condition code, sampled with br_req
- br_valid  output  1  one-cycle pulse, result of the previous request
- br_taken  output  1  condition outcome, meaningful when br_valid=1
- z_flag  output  1  stored Z
- c_flag  output  1  stored C
- n_flag  output  1  stored N
- v_flag  output  1  stored V
- zero_run  output  ZRUN_W  consecutive zero results, saturating

Behaviour:
- Reset (rst=1 at clock edge):
  - z_flag, c_flag, n_flag, v_flag, br_valid, br_taken all 0.
  - zero_run = 0.
  - Any request in flight is dropped: no br_valid after reset.
- Flag register priority: rst > flags_clr > flag_we > hold.
  - flags_clr=1: all four flags and zero_run go to 0 next cycle; flag_we is ignored that cycle.
  - flag_we=1: all four flags load their *_in values next cycle. No partial updates.
- zero_run:
  - On flag_we with z_in=1: increments by 1, saturating at 2^ZRUN_W-1 (15 by default); never wraps.
  - On flag_we with z_in=0: goes to 0.
  - Without flag_we: unchanged.
- Condition encoding (F = the evaluated flag set):
  - 000 always = 1
  - 001 EQ = Z
  - 010 NE = !Z
  - 011 CS = C
  - 100 CC = !C
  - 101 MI = N
  - 110 PL = !N
  - 111 VS = V
- Evaluated flag set F:
  - BYPASS=1 and flag_we=1 and flags_clr=0 in the request cycle: F = incoming z_in/c_in/n_in/v_in.
  - BYPASS=1 and flags_clr=1 in the request cycle: F = all zeros.
  - Otherwise: F = the currently stored flags.
- Latency:
  - br_req=1 at edge t gives br_valid=1 and br_taken=result during cycle t+1.
  - Back-to-back requests are accepted every cycle, one result per request, in order. No stall, no backpressure.
- br_valid is 0 in any cycle not following a request. br_taken is driven to 0 when br_valid=0.
- Combinational inputs are sampled only at the clock edge. Outputs are purely registered, with no combinational path from inputs to outputs.
- Boundaries:
  - A request in the same cycle as rst=1 is discarded.
  - When the counter is saturated and z_in=1, it holds at max.
  - flags_clr together with br_req follows the BYPASS rule above.

Test Plan:
- Reset, then flag_we=1 with z_in=1, c/n/v=0; next cycle z_flag=1, zero_run=1; br_req with cond=001 -> next cycle br_valid=1, br_taken=1.
- Same-cycle hazard: stored Z=1; drive flag_we=1, z_in=0 with br_req, cond=001.
  - BYPASS=1 -> br_taken=0.
  - BYPASS=0 -> br_taken=1.
- Sixteen consecutive flag_we with z_in=1 -> zero_run reads 1..15, then stays 15. One flag_we with z_in=0 -> zero_run=0.
- Walk cond 000..111 with stored flags Z=0, C=1, N=1, V=0, one request per cycle, back-to-back -> br_taken sequence 1,0,1,1,0,1,0,0 with br_valid high eight consecutive cycles.
- flags_clr and flag_we together with c_in=1 -> all flags 0, zero_run=0; br_req cond=011 in the same cycle (BYPASS=1) -> br_taken=0.
- br_req at edge t, rst=1 at edge t+1 -> br_valid stays 0 at t+1 and t+2; all flags 0.

Source files
------------

// File: rtl/flag_branch_unit.sv
// Z/C/N/V status register with branch-condition evaluation and a saturating
// consecutive-zero run counter. Branch results are registered, one cycle after request.
module flag_branch_unit #(
    parameter int BYPASS = 1,
    parameter int ZRUN_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flag_we,
    input  logic              z_in,
    input  logic              c_in,
    input  logic              n_in,
    input  logic              v_in,
    input  logic              flags_clr,
    input  logic              br_req,
    input  logic [2:0]        cond,
    output logic              br_valid,
    output logic              br_taken,
    output logic              z_flag,
    output logic              c_flag,
    output logic              n_flag,
    output logic              v_flag,
    output logic [ZRUN_W-1:0] zero_run
);

    localparam logic [ZRUN_W-1:0] ZRUN_MAX = '1;

    logic f_z, f_c, f_n, f_v;
    logic cond_true;

    // Evaluated flag set: a same-cycle clear or update wins over the stored flags when bypassing.
    always_comb begin
        f_z = z_flag;
        f_c = c_flag;
        f_n = n_flag;
        f_v = v_flag;
        if (BYPASS != 0) begin
            if (flags_clr) begin
                f_z = 1'b0;
                f_c = 1'b0;
                f_n = 1'b0;
                f_v = 1'b0;
            end else if (flag_we) begin
                f_z = z_in;
                f_c = c_in;
                f_n = n_in;
                f_v = v_in;
            end
        end
    end

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            3'b000:  cond_true = 1'b1;
            3'b001:  cond_true = f_z;
            3'b010:  cond_true = !f_z;
            3'b011:  cond_true = f_c;
            3'b100:  cond_true = !f_c;
            3'b101:  cond_true = f_n;
            3'b110:  cond_true = !f_n;
            3'b111:  cond_true = f_v;
            default: cond_true = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flags_clr) begin
            z_flag   <= 1'b0;
            c_flag   <= 1'b0;
            n_flag   <= 1'b0;
            v_flag   <= 1'b0;
            zero_run <= '0;
        end else if (flag_we) begin
            z_flag <= z_in;
            c_flag <= c_in;
            n_flag <= n_in;
            v_flag <= v_in;
            if (!z_in)
                zero_run <= '0;
            else if (zero_run != ZRUN_MAX)
                zero_run <= zero_run + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            br_valid <= 1'b0;
            br_taken <= 1'b0;
        end else begin
            br_valid <= br_req;
            br_taken <= br_req & cond_true;
        end
    end

endmodule

// File: tb/tb_flag_branch_unit.sv
// Scoreboarded bench: two instances (BYPASS=1 and BYPASS=0) share stimulus;
// expected branch results are queued at issue and popped by per-instance monitors.
module tb_flag_branch_unit;

    logic clk = 1'b0;
    logic rst, flag_we, z_in, c_in, n_in, v_in, flags_clr, br_req;
    logic [2:0] cond;
    logic br_valid0, br_taken0, z0, c0, n0, v0;
    logic br_valid1, br_taken1, z1, c1, n1, v1;
    logic [3:0] zrun0, zrun1;

    int total = 0;
    int passed = 0;
    bit q0[$];
    bit q1[$];

    always #5 clk = ~clk;

    flag_branch_unit #(.BYPASS(1), .ZRUN_W(4)) dut0 (
        .clk(clk), .rst(rst), .flag_we(flag_we), .z_in(z_in), .c_in(c_in),
        .n_in(n_in), .v_in(v_in), .flags_clr(flags_clr), .br_req(br_req),
        .cond(cond), .br_valid(br_valid0), .br_taken(br_taken0),
        .z_flag(z0), .c_flag(c0), .n_flag(n0), .v_flag(v0), .zero_run(zrun0));

    flag_branch_unit #(.BYPASS(0), .ZRUN_W(4)) dut1 (
        .clk(clk), .rst(rst), .flag_we(flag_we), .z_in(z_in), .c_in(c_in),
        .n_in(n_in), .v_in(v_in), .flags_clr(flags_clr), .br_req(br_req),
        .cond(cond), .br_valid(br_valid1), .br_taken(br_taken1),
        .z_flag(z1), .c_flag(c1), .n_flag(n1), .v_flag(v1), .zero_run(zrun1));

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitors: every br_valid pulse must match the oldest outstanding expectation.
    always @(posedge clk) begin
        #1;
        if (br_valid0) begin
            if (q0.size() == 0) chk("bypass1 unexpected br_valid", 1, 0);
            else chk("bypass1 br_taken", int'(br_taken0), int'(q0.pop_front()));
        end else begin
            chk("bypass1 br_taken idle", int'(br_taken0), 0);
        end
        if (br_valid1) begin
            if (q1.size() == 0) chk("bypass0 unexpected br_valid", 1, 0);
            else chk("bypass0 br_taken", int'(br_taken1), int'(q1.pop_front()));
        end
    end

    task automatic idle_inputs();
        rst = 0; flag_we = 0; z_in = 0; c_in = 0; n_in = 0; v_in = 0;
        flags_clr = 0; br_req = 0; cond = 3'b000;
    endtask

    // One clock: drive inputs, queue expected results if requesting, advance past the edge.
    task automatic cyc(input bit r, input bit we, input bit z, input bit c, input bit n,
                       input bit v, input bit clr, input bit req, input logic [2:0] cd,
                       input bit exp0, input bit exp1);
        rst = r; flag_we = we; z_in = z; c_in = c; n_in = n; v_in = v;
        flags_clr = clr; br_req = req; cond = cd;
        if (req && !r) begin
            q0.push_back(exp0);
            q1.push_back(exp1);
        end
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic chk_flags(input string name, input int z, input int c, input int n,
                             input int v, input int zr);
        chk({name, " z"}, int'(z0), z);
        chk({name, " c"}, int'(c0), c);
        chk({name, " n"}, int'(n0), n);
        chk({name, " v"}, int'(v0), v);
        chk({name, " zero_run"}, int'(zrun0), zr);
    endtask

    initial begin
        bit [7:0] walk_exp;
        idle_inputs();
        // Reset held with a request: the request must be discarded.
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 3'b000, 0, 0);
        cyc(1, 1, 1, 1, 1, 1, 0, 1, 3'b000, 0, 0);
        chk("reset br_valid", int'(br_valid0), 0);
        chk_flags("reset", 0, 0, 0, 0, 0);

        cyc(0, 1, 1, 0, 0, 0, 0, 0, 3'b000, 0, 0);
        chk_flags("first z", 1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 3'b001, 1, 1);
        chk("eq br_valid", int'(br_valid0), 1);

        // Same-cycle hazard: stored Z=1, update to Z=0 with an EQ request.
        cyc(0, 1, 0, 0, 0, 0, 0, 1, 3'b001, 0, 1);
        chk_flags("hazard", 0, 0, 0, 0, 0);

        // Run counter climbs to 15 and saturates, then clears on a nonzero result.
        for (int i = 1; i <= 16; i++) begin
            cyc(0, 1, 1, 0, 0, 0, 0, 0, 3'b000, 0, 0);
            chk("zero_run climb", int'(zrun0), (i > 15) ? 15 : i);
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0);
        chk("zero_run hold no we", int'(zrun0), 15);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0);
        chk("zero_run cleared", int'(zrun0), 0);

        // Condition walk against Z=0 C=1 N=1 V=0, back-to-back.
        cyc(0, 1, 0, 1, 1, 0, 0, 0, 3'b000, 0, 0);
        chk_flags("walk setup", 0, 1, 1, 0, 0);
        walk_exp = 8'b0010_1101; // bit k = expected result for cond k
        for (int k = 0; k < 8; k++) begin
            cyc(0, 0, 0, 0, 0, 0, 0, 1, 3'(k), walk_exp[k], walk_exp[k]);
            chk("walk br_valid", int'(br_valid0), 1);
        end

        // Clear beats update; CS request sees cleared flags only when bypassing.
        cyc(0, 1, 1, 1, 1, 1, 1, 1, 3'b011, 0, 1);
        chk_flags("clear", 0, 0, 0, 0, 0);
        chk("clear bypass0 c", int'(c1), 0);

        // Request immediately followed by reset: its pulse precedes the reset, nothing after.
        cyc(0, 1, 1, 1, 0, 0, 0, 0, 3'b000, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 3'b011, 1, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0);
        chk("post reset br_valid", int'(br_valid0), 0);
        chk_flags("post reset", 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0);
        chk("idle br_valid", int'(br_valid0), 0);

        repeat (3) @(posedge clk);
        #2;
        chk("bypass1 results outstanding", q0.size(), 0);
        chk("bypass0 results outstanding", q1.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
